// File: rtl/count_cap_pkg.sv
// Shared types and defaults for the count-bus event timestamp capture block.
package count_cap_pkg;

  typedef enum logic [1:0] {RISE, FALL, BOTH} edge_mode_e;

  localparam int CNT_W_DEFAULT = 16;

  typedef logic [CNT_W_DEFAULT-1:0] ts_t;

endpackage

// File: rtl/ts_fifo.sv
// First-word-fall-through timestamp FIFO with push/pop arbitration and
// an overflow strobe for pushes that find no free slot.
module ts_fifo
  import count_cap_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT,
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   resetN,
  input  logic                   push,
  input  logic [CNT_W-1:0]       push_data,
  input  logic                   pop_ready,
  output logic [CNT_W-1:0]       head_data,
  output logic                   head_valid,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [CNT_W-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             full;
  logic             pop;
  logic             push_ok;

  // A pop in the same cycle frees the head slot, so a push into a full FIFO still lands.
  assign full     = (level_q == LVL_W'(DEPTH));
  assign pop      = (level_q != '0) & pop_ready;
  assign push_ok  = push & (~full | pop);
  assign overflow = push & full & ~pop;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push_ok & ~pop) begin
      level_d = level_q + LVL_W'(1);
    end else if (pop & ~push_ok) begin
      level_d = level_q - LVL_W'(1);
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign head_data  = mem_q[rd_ptr_q];
  assign head_valid = (level_q != '0);
  assign level      = level_q;

endmodule

// File: rtl/count_event_capture.sv
// Captures the count bus on qualified edges of an asynchronous event line and
// queues the timestamps; tracks events dropped while the queue is full.
module count_event_capture
  import count_cap_pkg::*;
#(
  parameter int         CNT_W       = CNT_W_DEFAULT,
  parameter int         DEPTH       = 4,
  parameter int         SYNC_STAGES = 2,
  parameter edge_mode_e EDGE_MODE   = RISE
) (
  input  logic                   clock,
  input  logic                   resetN,
  input  logic [CNT_W-1:0]       count,
  input  logic                   event_in,
  output logic [CNT_W-1:0]       ts_data,
  output logic                   ts_valid,
  input  logic                   ts_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   ts_lost,
  output logic [7:0]             drop_cnt,
  input  logic                   clear_lost
);

  localparam int ARM_MAX = SYNC_STAGES + 1;
  localparam int ARM_W   = $clog2(ARM_MAX + 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   ev_d_q, ev_d_d;
  logic [ARM_W-1:0]       arm_q, arm_d;
  logic                   ts_lost_q, ts_lost_d;
  logic [7:0]             drop_cnt_q, drop_cnt_d;
  logic                   ev_s;
  logic                   armed;
  logic                   edge_hit;
  logic                   push;
  logic                   overflow;

  assign ev_s  = sync_q[SYNC_STAGES-1];
  assign armed = (arm_q == ARM_W'(ARM_MAX));

  // The arm counter masks detection until the synchroniser and edge history hold real samples.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], event_in};
    ev_d_d = ev_s;
    arm_d  = armed ? arm_q : arm_q + ARM_W'(1);
  end

  always_comb begin
    case (EDGE_MODE)
      RISE:    edge_hit = ev_s & ~ev_d_q;
      FALL:    edge_hit = ~ev_s & ev_d_q;
      default: edge_hit = ev_s ^ ev_d_q;
    endcase
  end

  assign push = armed & edge_hit;

  // A drop coinciding with clear_lost restarts the tally at one instead of zero.
  always_comb begin
    ts_lost_d  = ts_lost_q;
    drop_cnt_d = drop_cnt_q;
    if (overflow) begin
      ts_lost_d = 1'b1;
      if (clear_lost) begin
        drop_cnt_d = 8'd1;
      end else if (drop_cnt_q != 8'hFF) begin
        drop_cnt_d = drop_cnt_q + 8'd1;
      end
    end else if (clear_lost) begin
      ts_lost_d  = 1'b0;
      drop_cnt_d = 8'd0;
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      sync_q     <= '0;
      ev_d_q     <= 1'b0;
      arm_q      <= '0;
      ts_lost_q  <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else begin
      sync_q     <= sync_d;
      ev_d_q     <= ev_d_d;
      arm_q      <= arm_d;
      ts_lost_q  <= ts_lost_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  ts_fifo #(
    .CNT_W (CNT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock      (clock),
    .resetN     (resetN),
    .push       (push),
    .push_data  (count),
    .pop_ready  (ts_ready),
    .head_data  (ts_data),
    .head_valid (ts_valid),
    .level      (level),
    .overflow   (overflow)
  );

  assign ts_lost  = ts_lost_q;
  assign drop_cnt = drop_cnt_q;

endmodule
